// File: rtl/multicycle_control_if.sv
// Bus between the multi-cycle control FSM (master) and the shared datapath (slave).
// Carries the opcode and memory handshake in, and all datapath controls and status out.
interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       OP;
  logic             MemReady;
  logic             PCWrite;
  logic             PCWriteCondEQ;
  logic             PCWriteCondNE;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic [1:0]       MemtoReg;
  logic [1:0]       RegDst;
  logic             RegWrite;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [2:0]       ALUOp;
  logic [1:0]       PCSource;
  logic             Illegal;
  logic             BusError;
  logic             InstrRetired;
  logic [CNT_W-1:0] RetiredCount;
  logic [3:0]       State;

  modport master (
    input  OP, MemReady,
    output PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           Illegal, BusError, InstrRetired, RetiredCount, State
  );

  modport slave (
    output OP, MemReady,
    input  PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           Illegal, BusError, InstrRetired, RetiredCount, State
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback over a
// shared datapath, stalls on MemReady, flags illegal opcodes and memory timeouts.
module multicycle_control #(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  multicycle_control_if.master bus
);
  typedef enum logic [3:0] {
    START     = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    R_EXEC    = 4'd3,
    R_WB      = 4'd4,
    I_EXEC    = 4'd5,
    I_WB      = 4'd6,
    MEM_ADDR  = 4'd7,
    MEM_READ  = 4'd8,
    MEM_WB    = 4'd9,
    MEM_WRITE = 4'd10,
    BRANCH    = 4'd11,
    JUMP      = 4'd12,
    JAL       = 4'd13,
    ILLEGAL   = 4'd14,
    HALT      = 4'd15
  } stateT;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  stateT            state;
  logic [7:0]       waitCnt;
  logic             busErrorReg;
  logic [CNT_W-1:0] retiredCnt;
  logic             memState;
  logic             timeout;
  logic             retire;

  assign memState = (state == FETCH) || (state == MEM_READ) || (state == MEM_WRITE);
  // The WAIT_MAX-th stalled cycle is the last one tolerated; a ready in that cycle still wins.
  assign timeout  = memState && !bus.MemReady && (waitCnt == WAIT_LAST);
  assign retire   = (state inside {R_WB, I_WB, MEM_WB, BRANCH, JUMP, JAL}) ||
                    ((state == MEM_WRITE) && bus.MemReady);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= START;
      waitCnt     <= '0;
      busErrorReg <= 1'b0;
      retiredCnt  <= '0;
    end else begin
      if (retire) begin
        retiredCnt <= retiredCnt + CNT_W'(1);
      end
      if (memState && !bus.MemReady && !timeout) begin
        waitCnt <= waitCnt + 8'd1;
      end else begin
        waitCnt <= '0;
      end
      if (timeout) begin
        busErrorReg <= 1'b1;
      end
      case (state)
        START:     state <= FETCH;
        FETCH:     if (bus.MemReady) state <= DECODE; else if (timeout) state <= HALT;
        DECODE: begin
          case (bus.OP)
            OP_RTYPE:                        state <= R_EXEC;
            OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: state <= I_EXEC;
            OP_LW, OP_SW:                     state <= MEM_ADDR;
            OP_BEQ, OP_BNE:                   state <= BRANCH;
            OP_J:                             state <= JUMP;
            OP_JAL:                           state <= JAL;
            default:                          state <= ILLEGAL;
          endcase
        end
        R_EXEC:    state <= R_WB;
        I_EXEC:    state <= I_WB;
        MEM_ADDR:  state <= (bus.OP == OP_LW) ? MEM_READ : MEM_WRITE;
        MEM_READ:  if (bus.MemReady) state <= MEM_WB; else if (timeout) state <= HALT;
        MEM_WRITE: if (bus.MemReady) state <= FETCH;  else if (timeout) state <= HALT;
        HALT:      state <= HALT;
        default:   state <= FETCH;
      endcase
    end
  end

  always_comb begin
    bus.PCWrite       = 1'b0;
    bus.PCWriteCondEQ = 1'b0;
    bus.PCWriteCondNE = 1'b0;
    bus.IorD          = 1'b0;
    bus.MemRead       = 1'b0;
    bus.MemWrite      = 1'b0;
    bus.IRWrite       = 1'b0;
    bus.MemtoReg      = 2'b00;
    bus.RegDst        = 2'b00;
    bus.RegWrite      = 1'b0;
    bus.ALUSrcA       = 1'b0;
    bus.ALUSrcB       = 2'b00;
    bus.ALUOp         = 3'b000;
    bus.PCSource      = 2'b00;
    bus.Illegal       = 1'b0;
    case (state)
      FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = bus.MemReady;
        bus.PCWrite = bus.MemReady;
      end
      DECODE:   bus.ALUSrcB = 2'b11;
      R_EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 3'b111;
      end
      R_WB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 2'b01;
      end
      I_EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        case (bus.OP)
          OP_ORI:  bus.ALUOp = 3'b010;
          OP_ANDI: bus.ALUOp = 3'b011;
          OP_LUI:  bus.ALUOp = 3'b101;
          default: bus.ALUOp = 3'b000;
        endcase
      end
      I_WB:     bus.RegWrite = 1'b1;
      MEM_ADDR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      MEM_READ: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      MEM_WB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 2'b01;
      end
      MEM_WRITE: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
      end
      BRANCH: begin
        bus.ALUSrcA       = 1'b1;
        bus.ALUOp         = 3'b001;
        bus.PCSource      = 2'b01;
        bus.PCWriteCondEQ = (bus.OP == OP_BEQ);
        bus.PCWriteCondNE = (bus.OP == OP_BNE);
      end
      JUMP: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b10;
      end
      JAL: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 2'b10;
        bus.MemtoReg = 2'b10;
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b10;
      end
      ILLEGAL:  bus.Illegal = 1'b1;
      default: ;
    endcase
  end

  assign bus.InstrRetired = retire;
  assign bus.RetiredCount = retiredCnt;
  assign bus.BusError     = busErrorReg;
  assign bus.State        = state;
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-level model builds the expected state walk
// per opcode and stall pattern; table vectors, corner sequences and random instructions.
module tb_multicycle_control;
  localparam int WAIT_MAX = 4;
  localparam int CNT_W    = 4;

  localparam logic [3:0] S_START = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2,  S_REXEC = 4'd3;
  localparam logic [3:0] S_RWB = 4'd4,    S_IEXEC = 4'd5,  S_IWB = 4'd6,     S_MADDR = 4'd7;
  localparam logic [3:0] S_MREAD = 4'd8,  S_MWB = 4'd9,    S_MWRITE = 4'd10, S_BRANCH = 4'd11;
  localparam logic [3:0] S_JUMP = 4'd12,  S_JAL = 4'd13,   S_ILLEGAL = 4'd14, S_HALT = 4'd15;

  typedef struct {
    logic [3:0] st;
    logic       ready;
    logic       retire;
  } cycT;

  typedef struct {
    logic [5:0] op;
    int         fw;
    int         mw;
    int         expRetire;
    int         expIllegal;
  } vecT;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_if #(.CNT_W(CNT_W)) bus ();

  multicycle_control #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [20:0] stateOut [16];
  logic [20:0] actCtrl;
  cycT         path [$];
  vecT         vecs [12];
  logic [5:0]  legalOps [11];
  int          checks = 0;
  int          errors = 0;
  int          modelRetired = 0;
  logic        expBusErr = 1'b0;
  int          dutRetires;
  int          dutIllegals;

  assign actCtrl = {bus.PCWrite, bus.PCWriteCondEQ, bus.PCWriteCondNE, bus.IorD, bus.MemRead,
                    bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite,
                    bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.Illegal};

  function automatic logic [20:0] mk(logic pcw, logic eq, logic ne, logic iord, logic mr,
                                     logic mw, logic irw, logic [1:0] m2r, logic [1:0] rd,
                                     logic rw, logic sa, logic [1:0] sb, logic [2:0] aop,
                                     logic [1:0] pcs, logic ill);
    return {pcw, eq, ne, iord, mr, mw, irw, m2r, rd, rw, sa, sb, aop, pcs, ill};
  endfunction

  // Opcode-dependent fields patched on top of the per-state table.
  function automatic logic [20:0] expCtrl(logic [3:0] st, logic [5:0] op, logic ready);
    logic [20:0] r;
    r = stateOut[st];
    if (st == S_FETCH) begin
      r[20] = ready;
      r[14] = ready;
    end
    if (st == S_IEXEC) begin
      case (op)
        6'h0d:   r[5:3] = 3'b010;
        6'h0c:   r[5:3] = 3'b011;
        6'h0f:   r[5:3] = 3'b101;
        default: r[5:3] = 3'b000;
      endcase
    end
    if (st == S_BRANCH) begin
      r[19] = (op == 6'h04);
      r[18] = (op == 6'h05);
    end
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic cycT mkCyc(logic [3:0] st, logic ready, logic retire);
    cycT c;
    c.st = st;
    c.ready = ready;
    c.retire = retire;
    return c;
  endfunction

  // Expected cycle-by-cycle walk of one instruction; non-memory cycles get a random MemReady.
  task automatic buildPath(logic [5:0] op, int fw, int mw);
    logic rnd;
    path.delete();
    if (fw >= WAIT_MAX) begin
      repeat (WAIT_MAX) path.push_back(mkCyc(S_FETCH, 1'b0, 1'b0));
      return;
    end
    repeat (fw) path.push_back(mkCyc(S_FETCH, 1'b0, 1'b0));
    path.push_back(mkCyc(S_FETCH, 1'b1, 1'b0));
    rnd = 1'($urandom_range(0, 1));
    path.push_back(mkCyc(S_DECODE, rnd, 1'b0));
    case (op)
      6'h00: begin
        path.push_back(mkCyc(S_REXEC, rnd, 1'b0));
        path.push_back(mkCyc(S_RWB, !rnd, 1'b1));
      end
      6'h08, 6'h0d, 6'h0c, 6'h0f: begin
        path.push_back(mkCyc(S_IEXEC, !rnd, 1'b0));
        path.push_back(mkCyc(S_IWB, rnd, 1'b1));
      end
      6'h23: begin
        path.push_back(mkCyc(S_MADDR, rnd, 1'b0));
        repeat (mw) path.push_back(mkCyc(S_MREAD, 1'b0, 1'b0));
        path.push_back(mkCyc(S_MREAD, 1'b1, 1'b0));
        path.push_back(mkCyc(S_MWB, rnd, 1'b1));
      end
      6'h2b: begin
        path.push_back(mkCyc(S_MADDR, rnd, 1'b0));
        repeat (mw) path.push_back(mkCyc(S_MWRITE, 1'b0, 1'b0));
        path.push_back(mkCyc(S_MWRITE, 1'b1, 1'b1));
      end
      6'h04, 6'h05: path.push_back(mkCyc(S_BRANCH, rnd, 1'b1));
      6'h02:        path.push_back(mkCyc(S_JUMP, rnd, 1'b1));
      6'h03:        path.push_back(mkCyc(S_JAL, rnd, 1'b1));
      default:      path.push_back(mkCyc(S_ILLEGAL, rnd, 1'b0));
    endcase
  endtask

  task automatic doCycle(logic [5:0] op, cycT c, string tag);
    @(negedge clk);
    bus.OP = op;
    bus.MemReady = c.ready;
    #1;
    check({tag, " State"}, 32'(bus.State), 32'(c.st));
    check({tag, " ctrl"}, 32'(actCtrl), 32'(expCtrl(c.st, op, c.ready)));
    check({tag, " InstrRetired"}, 32'(bus.InstrRetired), 32'(c.retire));
    check({tag, " BusError"}, 32'(bus.BusError), 32'(expBusErr));
    check({tag, " RetiredCount"}, 32'(bus.RetiredCount), 32'(modelRetired % (1 << CNT_W)));
    dutRetires  += int'(bus.InstrRetired);
    dutIllegals += int'(bus.Illegal);
    if (c.retire) modelRetired++;
  endtask

  task automatic runInstr(logic [5:0] op, int fw, int mw, string tag);
    buildPath(op, fw, mw);
    dutRetires = 0;
    dutIllegals = 0;
    foreach (path[i]) doCycle(op, path[i], tag);
    $display("%s op=%02h fetchWait=%0d memWait=%0d cycles=%0d retired=%0d illegal=%0d count=%0d",
             tag, op, fw, mw, path.size(), dutRetires, dutIllegals, bus.RetiredCount);
  endtask

  task automatic checkResetState(string tag);
    check({tag, " State"}, 32'(bus.State), 32'(S_START));
    check({tag, " ctrl"}, 32'(actCtrl), 32'd0);
    check({tag, " InstrRetired"}, 32'(bus.InstrRetired), 32'd0);
    check({tag, " BusError"}, 32'(bus.BusError), 32'd0);
    check({tag, " RetiredCount"}, 32'(bus.RetiredCount), 32'd0);
  endtask

  initial begin
    stateOut[S_START]   = '0;
    stateOut[S_FETCH]   = mk(0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 2'b01, 3'b000, 2'b00, 0);
    stateOut[S_DECODE]  = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b11, 3'b000, 2'b00, 0);
    stateOut[S_REXEC]   = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b00, 3'b111, 2'b00, 0);
    stateOut[S_RWB]     = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 1, 0, 2'b00, 3'b000, 2'b00, 0);
    stateOut[S_IEXEC]   = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10, 3'b000, 2'b00, 0);
    stateOut[S_IWB]     = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 2'b00, 3'b000, 2'b00, 0);
    stateOut[S_MADDR]   = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10, 3'b000, 2'b00, 0);
    stateOut[S_MREAD]   = mk(0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 3'b000, 2'b00, 0);
    stateOut[S_MWB]     = mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 1, 0, 2'b00, 3'b000, 2'b00, 0);
    stateOut[S_MWRITE]  = mk(0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0, 2'b00, 3'b000, 2'b00, 0);
    stateOut[S_BRANCH]  = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b00, 3'b001, 2'b01, 0);
    stateOut[S_JUMP]    = mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 3'b000, 2'b10, 0);
    stateOut[S_JAL]     = mk(1, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 1, 0, 2'b00, 3'b000, 2'b10, 0);
    stateOut[S_ILLEGAL] = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 3'b000, 2'b00, 1);
    stateOut[S_HALT]    = '0;

    legalOps = '{6'h00, 6'h08, 6'h0d, 6'h0c, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03};

    vecs[0]  = '{op: 6'h00, fw: 0, mw: 0, expRetire: 1, expIllegal: 0};
    vecs[1]  = '{op: 6'h23, fw: 0, mw: 3, expRetire: 1, expIllegal: 0};
    vecs[2]  = '{op: 6'h04, fw: 0, mw: 0, expRetire: 1, expIllegal: 0};
    vecs[3]  = '{op: 6'h05, fw: 0, mw: 0, expRetire: 1, expIllegal: 0};
    vecs[4]  = '{op: 6'h03, fw: 0, mw: 0, expRetire: 1, expIllegal: 0};
    vecs[5]  = '{op: 6'h3f, fw: 0, mw: 0, expRetire: 0, expIllegal: 1};
    vecs[6]  = '{op: 6'h2b, fw: 1, mw: 2, expRetire: 1, expIllegal: 0};
    vecs[7]  = '{op: 6'h08, fw: 0, mw: 0, expRetire: 1, expIllegal: 0};
    vecs[8]  = '{op: 6'h0d, fw: 0, mw: 0, expRetire: 1, expIllegal: 0};
    vecs[9]  = '{op: 6'h0c, fw: 3, mw: 0, expRetire: 1, expIllegal: 0};
    vecs[10] = '{op: 6'h0f, fw: 0, mw: 0, expRetire: 1, expIllegal: 0};
    vecs[11] = '{op: 6'h02, fw: 2, mw: 0, expRetire: 1, expIllegal: 0};

    bus.OP = 6'h00;
    bus.MemReady = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checkResetState("reset");
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkResetState("release");

    foreach (vecs[i]) begin
      runInstr(vecs[i].op, vecs[i].fw, vecs[i].mw, $sformatf("vec%0d", i));
      check($sformatf("vec%0d retires", i), 32'(dutRetires), 32'(vecs[i].expRetire));
      check($sformatf("vec%0d illegals", i), 32'(dutIllegals), 32'(vecs[i].expIllegal));
    end

    // Reset while a store is stalled: no strobe survives, count clears.
    buildPath(6'h2b, 0, 2);
    for (int i = 0; i < 4; i++) doCycle(6'h2b, path[i], "swReset");
    @(negedge clk);
    reset = 1'b0;
    bus.MemReady = 1'b1;
    #1;
    modelRetired = 0;
    checkResetState("swReset asserted");
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkResetState("swReset released");
    runInstr(6'h00, 0, 0, "afterSwReset");

    for (int n = 0; n < 40; n++) begin
      logic [5:0] op;
      if ($urandom_range(0, 3) == 0) op = 6'($urandom_range(0, 63));
      else op = legalOps[$urandom_range(0, 10)];
      runInstr(op, $urandom_range(0, WAIT_MAX - 1), $urandom_range(0, WAIT_MAX - 1),
               $sformatf("rnd%0d", n));
    end

    // Fetch timeout: WAIT_MAX stalled cycles, then sticky HALT until reset.
    runInstr(6'h00, WAIT_MAX, 0, "timeout");
    expBusErr = 1'b1;
    doCycle(6'h00, mkCyc(S_HALT, 1'b0, 1'b0), "halt0");
    doCycle(6'h00, mkCyc(S_HALT, 1'b1, 1'b0), "halt1");
    doCycle(6'h23, mkCyc(S_HALT, 1'b1, 1'b0), "halt2");
    @(negedge clk);
    reset = 1'b0;
    #1;
    expBusErr = 1'b0;
    modelRetired = 0;
    checkResetState("haltReset asserted");
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkResetState("haltReset released");
    runInstr(6'h03, 0, 0, "afterHalt");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
